// File: rtl/ps2_mouse_cursor.sv
// ps2_mouse_cursor: turns decoded PS/2 mouse packets into an absolute,
// screen-clamped cursor position, button state and click pulses.
// Sequence per packet: IDLE -> CAPTURE -> CHECK -> CALC -> PUBLISH -> IDLE.
// Optional feature macro: PS2_CURSOR_ACCEL_EN doubles deltas whose magnitude exceeds 8.
module ps2_mouse_cursor #(
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int X_INIT   = 320,
    parameter int Y_INIT   = 240,
    parameter int COORD_W  = 10,
    parameter int Y_INVERT = 1
) (
    input  logic               qzt_clk,
    input  logic               rst_n,
    input  logic               pkt_strobe,
    input  logic [7:0]         status_pck,
    input  logic [7:0]         xm_pck,
    input  logic [7:0]         ym_pck,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic [2:0]         buttons,
    output logic [2:0]         click,
    output logic               update,
    output logic [7:0]         sync_err_cnt,
    output logic [7:0]         ovf_cnt
);

    // Arithmetic width: two guard bits keep cursor +/- delta from wrapping.
    localparam int S = COORD_W + 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CAPTURE = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_CALC    = 3'd3;
    localparam logic [2:0] ST_PUBLISH = 3'd4;

    localparam logic [COORD_W-1:0] XMAX_C  = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YMAX_C  = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] XINIT_C = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0] YINIT_C = COORD_W'(Y_INIT);

`ifdef PS2_CURSOR_ACCEL_EN
    localparam logic signed [S-1:0] ACC_POS = S'(8);
    localparam logic signed [S-1:0] ACC_NEG = S'(-8);
`endif

    logic [2:0]          r_state;
    logic                r_strobe_q;
    logic [7:0]          r_status;
    logic [7:0]          r_xm;
    logic [7:0]          r_ym;
    logic [8:0]          r_dx;
    logic [8:0]          r_dy;

    logic                w_edge;
    logic signed [S-1:0] w_dx_ext;
    logic signed [S-1:0] w_dy_ext;
    logic signed [S-1:0] w_dx_eff;
    logic signed [S-1:0] w_dy_eff;
    logic signed [S-1:0] w_nx;
    logic signed [S-1:0] w_ny;

    // Saturate a signed intermediate coordinate into 0..vmax.
    function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [S-1:0] v,
                                                       input logic [COORD_W-1:0] vmax);
        logic [COORD_W-1:0] res;
        if (v[S-1]) begin
            res = {COORD_W{1'b0}};
        end else if (v > $signed({2'b00, vmax})) begin
            res = vmax;
        end else begin
            res = v[COORD_W-1:0];
        end
        return res;
    endfunction

    // Saturating 8-bit increment for the diagnostic counters.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        logic [7:0] res;
        if (c == 8'hFF) begin
            res = c;
        end else begin
            res = c + 8'd1;
        end
        return res;
    endfunction

    assign w_edge = pkt_strobe & ~r_strobe_q;

    // Delta scaling and the next (unclamped) cursor position.
    always_comb begin
        w_dx_ext = {{(S-9){r_dx[8]}}, r_dx};
        w_dy_ext = {{(S-9){r_dy[8]}}, r_dy};
        w_dx_eff = w_dx_ext;
        w_dy_eff = w_dy_ext;
`ifdef PS2_CURSOR_ACCEL_EN
        if ((w_dx_ext > ACC_POS) || (w_dx_ext < ACC_NEG)) begin
            w_dx_eff = w_dx_ext <<< 1;
        end else begin
            w_dx_eff = w_dx_ext;
        end
        if ((w_dy_ext > ACC_POS) || (w_dy_ext < ACC_NEG)) begin
            w_dy_eff = w_dy_ext <<< 1;
        end else begin
            w_dy_eff = w_dy_ext;
        end
`endif
        w_nx = $signed({2'b00, cursor_x}) + w_dx_eff;
        if (Y_INVERT != 0) begin
            w_ny = $signed({2'b00, cursor_y}) - w_dy_eff;
        end else begin
            w_ny = $signed({2'b00, cursor_y}) + w_dy_eff;
        end
    end

    // Strobe history: tracks every cycle so a long strobe triggers only once.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe_q <= 1'b0;
        end else begin
            r_strobe_q <= pkt_strobe;
        end
    end

    // Packet sequencer; outputs are loaded on entry to PUBLISH so they are
    // valid (and update/click high) for exactly the PUBLISH cycle.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_status     <= 8'h00;
            r_xm         <= 8'h00;
            r_ym         <= 8'h00;
            r_dx         <= 9'd0;
            r_dy         <= 9'd0;
            cursor_x     <= XINIT_C;
            cursor_y     <= YINIT_C;
            buttons      <= 3'b000;
            click        <= 3'b000;
            update       <= 1'b0;
            sync_err_cnt <= 8'h00;
            ovf_cnt      <= 8'h00;
        end else begin
            click  <= 3'b000;
            update <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_status <= status_pck;
                    r_xm     <= xm_pck;
                    r_ym     <= ym_pck;
                    r_state  <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (!r_status[3]) begin
                        sync_err_cnt <= sat_inc(sync_err_cnt);
                        r_state      <= ST_IDLE;
                    end else begin
                        r_dx <= r_status[6] ? 9'd0 : {r_status[4], r_xm};
                        r_dy <= r_status[7] ? 9'd0 : {r_status[5], r_ym};
                        if (r_status[6] || r_status[7]) begin
                            ovf_cnt <= sat_inc(ovf_cnt);
                        end
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    cursor_x <= clamp_coord(w_nx, XMAX_C);
                    cursor_y <= clamp_coord(w_ny, YMAX_C);
                    buttons  <= r_status[2:0];
                    click    <= r_status[2:0] & ~buttons;
                    update   <= 1'b1;
                    r_state  <= ST_PUBLISH;
                end
                ST_PUBLISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Directed bench for ps2_mouse_cursor (default parameters, Y inverted).
module tb_ps2_mouse_cursor;

    logic       qzt_clk;
    logic       rst_n;
    logic       pkt_strobe;
    logic [7:0] status_pck;
    logic [7:0] xm_pck;
    logic [7:0] ym_pck;
    logic [9:0] cursor_x;
    logic [9:0] cursor_y;
    logic [2:0] buttons;
    logic [2:0] click;
    logic       update;
    logic [7:0] sync_err_cnt;
    logic [7:0] ovf_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int n_upd;
    logic [2:0] clk_seen;

    ps2_mouse_cursor dut (
        .qzt_clk     (qzt_clk),
        .rst_n       (rst_n),
        .pkt_strobe  (pkt_strobe),
        .status_pck  (status_pck),
        .xm_pck      (xm_pck),
        .ym_pck      (ym_pck),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .buttons     (buttons),
        .click       (click),
        .update      (update),
        .sync_err_cnt(sync_err_cnt),
        .ovf_cnt     (ovf_cnt)
    );

    initial qzt_clk = 1'b0;
    always #5 qzt_clk = ~qzt_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Raise the strobe with a packet, hold it for 'hold' cycles, then drop it.
    // Reports cycles-to-first-update (-1 if none), number of update cycles and
    // the click value seen with the first update.
    task automatic send_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y,
                            input int hold, output int latency, output int updates,
                            output logic [2:0] clicks);
        @(negedge qzt_clk);
        status_pck = s;
        xm_pck     = x;
        ym_pck     = y;
        pkt_strobe = 1'b1;
        latency = -1;
        updates = 0;
        clicks  = 3'b000;
        for (int i = 1; i <= hold; i++) begin
            @(posedge qzt_clk);
            #1;
            if (update) begin
                updates++;
                if (latency < 0) begin
                    latency = i;
                    clicks  = click;
                end
            end
        end
        @(negedge qzt_clk);
        pkt_strobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge qzt_clk);
            #1;
            if (update) updates++;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pkt_strobe = 1'b0;
        status_pck = 8'h00;
        xm_pck     = 8'h00;
        ym_pck     = 8'h00;
        repeat (3) @(posedge qzt_clk);
        #1;
        check("rst_x", cursor_x, 320);
        check("rst_y", cursor_y, 240);
        check("rst_btn", buttons, 0);
        check("rst_click", click, 0);
        check("rst_upd", update, 0);
        check("rst_sync", sync_err_cnt, 0);
        check("rst_ovf", ovf_cnt, 0);
        @(negedge qzt_clk);
        rst_n = 1'b1;
        repeat (2) @(posedge qzt_clk);

        // Basic move: +5 X, +3 Y (inverted -> up)
        send_pkt(8'h08, 8'h05, 8'h03, 10, lat, n_upd, clk_seen);
        check("p1_lat", lat, 4);
        check("p1_nupd", n_upd, 1);
        check("p1_x", cursor_x, 325);
        check("p1_y", cursor_y, 237);
        check("p1_btn", buttons, 0);
        check("p1_click", clk_seen, 0);

        // L pressed, X -10
        send_pkt(8'h19, 8'hF6, 8'h00, 10, lat, n_upd, clk_seen);
        check("p2_x", cursor_x, 315);
        check("p2_y", cursor_y, 237);
        check("p2_btn", buttons, 1);
        check("p2_click", clk_seen, 1);
        check("p2_click_after", click, 0);
        send_pkt(8'h19, 8'hF6, 8'h00, 10, lat, n_upd, clk_seen);
        check("p3_x", cursor_x, 305);
        check("p3_btn", buttons, 1);
        check("p3_click", clk_seen, 0);

        // Walk X down to 5, then clamp at 0
        send_pkt(8'h18, 8'h80, 8'h00, 10, lat, n_upd, clk_seen);
        send_pkt(8'h18, 8'h80, 8'h00, 10, lat, n_upd, clk_seen);
        check("walk_x49", cursor_x, 49);
        send_pkt(8'h18, 8'hD4, 8'h00, 10, lat, n_upd, clk_seen);
        check("walk_x5", cursor_x, 5);
        check("walk_btn", buttons, 0);
        send_pkt(8'h18, 8'h80, 8'h00, 10, lat, n_upd, clk_seen);
        check("clamp_x0", cursor_x, 0);
        send_pkt(8'h18, 8'h80, 8'h00, 10, lat, n_upd, clk_seen);
        check("hold_x0", cursor_x, 0);

        // Walk Y down the screen to 470, then clamp at 479
        send_pkt(8'h28, 8'h00, 8'h80, 10, lat, n_upd, clk_seen);
        check("walk_y365", cursor_y, 365);
        send_pkt(8'h28, 8'h00, 8'h97, 10, lat, n_upd, clk_seen);
        check("walk_y470", cursor_y, 470);
        send_pkt(8'h28, 8'h00, 8'hE0, 10, lat, n_upd, clk_seen);
        check("clamp_y479", cursor_y, 479);
        send_pkt(8'h28, 8'h00, 8'h80, 10, lat, n_upd, clk_seen);
        check("hold_y479", cursor_y, 479);
        check("hold_y_x", cursor_x, 0);

        // Extreme +255 X steps up to the right edge
        send_pkt(8'h08, 8'hFF, 8'h00, 10, lat, n_upd, clk_seen);
        check("xp_255", cursor_x, 255);
        send_pkt(8'h08, 8'hFF, 8'h00, 10, lat, n_upd, clk_seen);
        check("xp_510", cursor_x, 510);
        send_pkt(8'h08, 8'hFF, 8'h00, 10, lat, n_upd, clk_seen);
        check("xp_639", cursor_x, 639);

        // X overflow with R pressed: X forced to 0, Y moves up 2
        send_pkt(8'h4A, 8'h7F, 8'h02, 10, lat, n_upd, clk_seen);
        check("ovf_x", cursor_x, 639);
        check("ovf_y", cursor_y, 477);
        check("ovf_cnt", ovf_cnt, 1);
        check("ovf_btn", buttons, 2);
        check("ovf_click", clk_seen, 2);

        // Sync error (bit3 clear): dropped entirely
        send_pkt(8'h05, 8'h10, 8'h10, 10, lat, n_upd, clk_seen);
        check("sync_nupd", n_upd, 0);
        check("sync_x", cursor_x, 639);
        check("sync_y", cursor_y, 477);
        check("sync_btn", buttons, 2);
        check("sync_cnt", sync_err_cnt, 1);
        check("sync_ovf", ovf_cnt, 1);

        // Strobe held for 500 cycles: exactly one packet
        send_pkt(8'h18, 8'hFF, 8'h01, 500, lat, n_upd, clk_seen);
        check("long_nupd", n_upd, 1);
        check("long_lat", lat, 4);
        check("long_x", cursor_x, 638);
        check("long_y", cursor_y, 476);
        check("long_btn", buttons, 0);

        // Reset asserted while the FSM is in CALC
        @(negedge qzt_clk);
        status_pck = 8'h08;
        xm_pck     = 8'h05;
        ym_pck     = 8'h05;
        pkt_strobe = 1'b1;
        repeat (3) @(posedge qzt_clk);
        #1;
        rst_n      = 1'b0;
        pkt_strobe = 1'b0;
        #1;
        check("midrst_x", cursor_x, 320);
        check("midrst_y", cursor_y, 240);
        check("midrst_sync", sync_err_cnt, 0);
        check("midrst_ovf", ovf_cnt, 0);
        @(negedge qzt_clk);
        rst_n = 1'b1;
        n_upd = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge qzt_clk);
            #1;
            if (update) n_upd++;
        end
        check("midrst_nupd", n_upd, 0);
        check("midrst_x2", cursor_x, 320);

        // Acceleration threshold: delta 10 then delta 8
        send_pkt(8'h08, 8'h0A, 8'h00, 10, lat, n_upd, clk_seen);
`ifdef PS2_CURSOR_ACCEL_EN
        check("acc_x10", cursor_x, 340);
`else
        check("acc_x10", cursor_x, 330);
`endif
        send_pkt(8'h08, 8'h08, 8'h00, 10, lat, n_upd, clk_seen);
`ifdef PS2_CURSOR_ACCEL_EN
        check("acc_x8", cursor_x, 348);
`else
        check("acc_x8", cursor_x, 338);
`endif
        check("acc_y", cursor_y, 240);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
